// File: rtl/dm.sv
// Debug Module shared types: DMI request/response bundles and DTM opcodes.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP      = 2'h0,
    DTM_READ     = 2'h1,
    DTM_WRITE    = 2'h2,
    DTM_RESERVED = 2'h3
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [1:0] DMI_RESP_ERR = 2'h2;

endpackage

// File: rtl/dmi_arb_pkg.sv
// Local helpers for the DMI arbiter slice.
// Index widths never collapse to zero bits.
package dmi_arb_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmi_arb_if.sv
// DMI arbiter bus bundle: per-master request/response side plus DM side.
// slave modport is the arbiter's view, master modport the surrounding logic.
interface dmi_arb_if #(
  parameter int unsigned NumPorts = 2
);
  import dm::*;

  dmi_req_t  [NumPorts-1:0] slv_dmi_req_i;
  logic      [NumPorts-1:0] slv_dmi_valid_i;
  logic      [NumPorts-1:0] slv_dmi_ready_o;
  dmi_resp_t [NumPorts-1:0] slv_dmi_resp_o;
  logic      [NumPorts-1:0] slv_dmi_valid_o;
  logic      [NumPorts-1:0] slv_dmi_ready_i;

  dmi_req_t  core_dmi_req_o;
  logic      core_dmi_valid_o;
  logic      core_dmi_ready_i;
  dmi_resp_t core_dmi_resp_i;
  logic      core_dmi_valid_i;
  logic      core_dmi_ready_o;

  modport slave (
    input  slv_dmi_req_i, slv_dmi_valid_i, slv_dmi_ready_i,
    input  core_dmi_ready_i, core_dmi_resp_i, core_dmi_valid_i,
    output slv_dmi_ready_o, slv_dmi_resp_o, slv_dmi_valid_o,
    output core_dmi_req_o, core_dmi_valid_o, core_dmi_ready_o
  );

  modport master (
    output slv_dmi_req_i, slv_dmi_valid_i, slv_dmi_ready_i,
    output core_dmi_ready_i, core_dmi_resp_i, core_dmi_valid_i,
    input  slv_dmi_ready_o, slv_dmi_resp_o, slv_dmi_valid_o,
    input  core_dmi_req_o, core_dmi_valid_o, core_dmi_ready_o
  );

endinterface

// File: rtl/dmi_arb_rr.sv
// Round-robin grant: first valid port at or after prio_i, wrapping.
// Purely combinational; independent of any ready.
module dmi_arb_rr
  import dmi_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  localparam int unsigned IdW = idx_w(NumPorts)
) (
  input  logic [NumPorts-1:0] valid_i,
  input  logic [IdW-1:0]      prio_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdW-1:0]      idx_o,
  output logic                any_o
);

  logic [IdW:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      j = {1'b0, prio_i} + (IdW+1)'(k);
      if (j >= (IdW+1)'(NumPorts)) j = j - (IdW+1)'(NumPorts);
      if (!any_o && valid_i[j[IdW-1:0]]) begin
        any_o              = 1'b1;
        gnt_o[j[IdW-1:0]]  = 1'b1;
        idx_o              = j[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/dmi_arb.sv
// N-to-1 DMI arbiter with registered request path and in-order ID queue.
// Optional response watchdog: define DMI_ARB_TIMEOUT_EN.
module dmi_arb
  import dm::*;
  import dmi_arb_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic      clk_i,
  input  logic      rst_i,
  dmi_arb_if.slave  bus
);

  localparam int unsigned IdW  = idx_w(NumPorts);
  localparam int unsigned PtrW = idx_w(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  if (NumPorts < 2 || MaxOutstanding < 1 || TimeoutCycles < 1) begin : g_bad
    $error("dmi_arb: illegal parameter set");
  end

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  dmi_req_t        req_q, req_d;
  logic            vld_q, vld_d;
  logic [IdW-1:0]  prio_q, prio_d;
  logic [IdW-1:0]  id_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumPorts-1:0] gnt, rsp_vld;
  logic [IdW-1:0]      gnt_idx, head;
  logic                any_vld, can_acc, push, pop, has_head, core_rdy;
  dmi_resp_t           rsp;

  dmi_arb_rr #(.NumPorts(NumPorts)) u_rr (
    .valid_i (bus.slv_dmi_valid_i),
    .prio_i  (prio_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (any_vld)
  );

  assign has_head = cnt_q != '0;
  assign head     = id_q[rptr_q];
  // count is checked before any same-cycle pop: no full-bypass
  assign can_acc  = (!vld_q || bus.core_dmi_ready_i)
                 && (cnt_q < CntW'(MaxOutstanding)) && !rst_i;
  assign push     = any_vld && can_acc;

  assign bus.slv_dmi_ready_o  = can_acc ? gnt : '0;
  assign bus.core_dmi_req_o   = req_q;
  assign bus.core_dmi_valid_o = vld_q;
  assign bus.slv_dmi_valid_o  = rsp_vld;
  assign bus.slv_dmi_resp_o   = {NumPorts{rsp}};
  assign bus.core_dmi_ready_o = core_rdy;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
  localparam dmi_resp_t TmoResp = '{data: 32'h0, resp: DMI_RESP_ERR};

  logic [WdW-1:0] wd_q, wd_d;
  logic [7:0]     stale_q, stale_d;
  logic           tmo;

  assign tmo = has_head && (wd_q == WdW'(TimeoutCycles));
`endif

  always_comb begin
    rsp_vld  = '0;
    rsp      = bus.core_dmi_resp_i;
    core_rdy = 1'b1;
    pop      = 1'b0;
    if (has_head) begin
      rsp_vld[head] = bus.core_dmi_valid_i;
      core_rdy      = bus.slv_dmi_ready_i[head];
      pop           = bus.core_dmi_valid_i && core_rdy;
    end
`ifdef DMI_ARB_TIMEOUT_EN
    // late answers for timed-out requests are swallowed
    if (stale_q != '0) begin
      rsp_vld  = '0;
      core_rdy = 1'b1;
      pop      = 1'b0;
    end
    if (tmo) begin
      rsp_vld       = '0;
      rsp_vld[head] = 1'b1;
      rsp           = TmoResp;
      core_rdy      = bus.slv_dmi_ready_i[head];
      pop           = core_rdy;
    end
`endif
    if (rst_i) begin
      rsp_vld = '0;
      rsp     = '0;
    end
  end

  always_comb begin
    req_d  = req_q;
    vld_d  = vld_q && !bus.core_dmi_ready_i;
    prio_d = prio_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      req_d  = bus.slv_dmi_req_i[gnt_idx];
      vld_d  = 1'b1;
      prio_d = (gnt_idx == IdW'(NumPorts - 1)) ? '0 : gnt_idx + IdW'(1);
      wptr_d = nxt(wptr_q);
    end
    if (pop) rptr_d = nxt(rptr_q);
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= '0;
      vld_q  <= 1'b0;
      prio_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) id_q[i] <= '0;
    end else begin
      req_q  <= req_d;
      vld_q  <= vld_d;
      prio_q <= prio_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push) id_q[wptr_q] <= gnt_idx;
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  always_comb begin
    wd_d = (pop || !has_head) ? '0 : (tmo ? wd_q : wd_q + WdW'(1));
    stale_d = stale_q;
    if (tmo && pop) begin
      if (!bus.core_dmi_valid_i && stale_q != '1) stale_d = stale_q + 8'd1;
    end else if (stale_q != '0 && bus.core_dmi_valid_i) begin
      stale_d = stale_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q    <= '0;
      stale_q <= '0;
    end else begin
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmi_arb.sv
// Directed bench for dmi_arb: vector table for arbitration/routing,
// hand sequences for reset, empty-queue discard and the watchdog.
module tb_dmi_arb;
  import dm::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmi_arb_if #(.NumPorts(2)) bus ();

  dmi_arb #(
    .NumPorts(2),
    .MaxOutstanding(2),
    .TimeoutCycles(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] vld;
    logic       crdy;
    logic       cvld;
    logic [1:0] srdy;
    logic [1:0] e_rdy;
    logic       e_cvld;
    logic [6:0] e_addr;
    logic [1:0] e_svld;
    logic       e_crdy;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.slv_dmi_req_i[0] = '{addr: 7'h11, op: DTM_READ, data: 32'h0};
    bus.slv_dmi_req_i[1] = '{addr: 7'h22, op: DTM_WRITE, data: 32'h1234};
    bus.slv_dmi_valid_i  = 2'b11;
    bus.slv_dmi_ready_i  = 2'b11;
    bus.core_dmi_ready_i = 1'b1;
    bus.core_dmi_valid_i = 1'b1;
    bus.core_dmi_resp_i  = '{data: 32'hDEADBEEF, resp: 2'h0};

    //        vld   cr  cv  srdy | rdy  cvo  addr   svld crdy
    tbl[0]  = '{2'b11, 1, 0, 2'b11, 2'b01, 0, 7'h00, 2'b00, 1};
    tbl[1]  = '{2'b11, 1, 0, 2'b11, 2'b10, 1, 7'h11, 2'b00, 1};
    tbl[2]  = '{2'b11, 1, 1, 2'b11, 2'b00, 1, 7'h22, 2'b01, 1};
    tbl[3]  = '{2'b11, 1, 1, 2'b11, 2'b01, 0, 7'h00, 2'b10, 1};
    tbl[4]  = '{2'b11, 1, 1, 2'b11, 2'b10, 1, 7'h11, 2'b01, 1};
    tbl[5]  = '{2'b00, 1, 0, 2'b11, 2'b00, 1, 7'h22, 2'b00, 1};
    tbl[6]  = '{2'b00, 1, 1, 2'b01, 2'b00, 0, 7'h00, 2'b10, 0};
    tbl[7]  = '{2'b00, 1, 1, 2'b11, 2'b00, 0, 7'h00, 2'b10, 1};
    tbl[8]  = '{2'b00, 1, 1, 2'b11, 2'b00, 0, 7'h00, 2'b00, 1};
    tbl[9]  = '{2'b10, 1, 0, 2'b11, 2'b10, 0, 7'h00, 2'b00, 1};
    tbl[10] = '{2'b01, 0, 0, 2'b11, 2'b00, 1, 7'h22, 2'b00, 1};
    tbl[11] = '{2'b01, 1, 0, 2'b11, 2'b01, 1, 7'h22, 2'b00, 1};
    tbl[12] = '{2'b11, 1, 0, 2'b11, 2'b00, 1, 7'h11, 2'b00, 1};
    tbl[13] = '{2'b11, 1, 0, 2'b11, 2'b00, 0, 7'h00, 2'b00, 1};
    tbl[14] = '{2'b11, 1, 1, 2'b11, 2'b00, 0, 7'h00, 2'b10, 1};
    tbl[15] = '{2'b11, 1, 0, 2'b11, 2'b10, 0, 7'h00, 2'b00, 1};
    tbl[16] = '{2'b11, 1, 0, 2'b11, 2'b00, 1, 7'h22, 2'b00, 1};

    // reset held with every valid high
    repeat (2) step();
    chk("rst_ready", 128'(bus.slv_dmi_ready_o), 128'(2'b00));
    chk("rst_core_valid", 128'(bus.core_dmi_valid_o), 128'(1'b0));
    chk("rst_slv_valid", 128'(bus.slv_dmi_valid_o), 128'(2'b00));
    chk("rst_core_req", 128'(bus.core_dmi_req_o), 128'(0));
    chk("rst_slv_resp", 128'(bus.slv_dmi_resp_o), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.slv_dmi_valid_i  = tbl[i].vld;
      bus.core_dmi_ready_i = tbl[i].crdy;
      bus.core_dmi_valid_i = tbl[i].cvld;
      bus.slv_dmi_ready_i  = tbl[i].srdy;
      #1;
      chk($sformatf("v%0d_ready", i),
          128'(bus.slv_dmi_ready_o), 128'(tbl[i].e_rdy));
      chk($sformatf("v%0d_core_valid", i),
          128'(bus.core_dmi_valid_o), 128'(tbl[i].e_cvld));
      if (tbl[i].e_cvld)
        chk($sformatf("v%0d_core_addr", i),
            128'(bus.core_dmi_req_o.addr), 128'(tbl[i].e_addr));
      chk($sformatf("v%0d_slv_valid", i),
          128'(bus.slv_dmi_valid_o), 128'(tbl[i].e_svld));
      chk($sformatf("v%0d_core_ready", i),
          128'(bus.core_dmi_ready_o), 128'(tbl[i].e_crdy));
      if (tbl[i].e_svld[0])
        chk($sformatf("v%0d_resp0_data", i),
            128'(bus.slv_dmi_resp_o[0].data), 128'(32'hDEADBEEF));
      step();
    end

    // reset with two requests in flight, then a late DM response
    rst = 1'b1;
    bus.slv_dmi_valid_i  = 2'b00;
    bus.core_dmi_valid_i = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_core_valid", 128'(bus.core_dmi_valid_o), 128'(1'b0));
    bus.core_dmi_valid_i = 1'b1;
    #1;
    chk("late_core_ready", 128'(bus.core_dmi_ready_o), 128'(1'b1));
    chk("late_slv_valid", 128'(bus.slv_dmi_valid_o), 128'(2'b00));
    chk("late_ready_idle", 128'(bus.slv_dmi_ready_o), 128'(2'b00));
    step();
    bus.core_dmi_valid_i = 1'b0;

`ifdef DMI_ARB_TIMEOUT_EN
    bus.slv_dmi_valid_i = 2'b01;
    #1;
    chk("tmo_accept", 128'(bus.slv_dmi_ready_o), 128'(2'b01));
    step();
    bus.slv_dmi_valid_i = 2'b00;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tmo_wait%0d", k),
          128'(bus.slv_dmi_valid_o), 128'(2'b00));
      step();
    end
    chk("tmo_valid", 128'(bus.slv_dmi_valid_o), 128'(2'b01));
    chk("tmo_resp", 128'(bus.slv_dmi_resp_o[0]), 128'({32'h0, 2'h2}));
    step();
    bus.core_dmi_valid_i = 1'b1;
    #1;
    chk("stale_core_ready", 128'(bus.core_dmi_ready_o), 128'(1'b1));
    chk("stale_slv_valid", 128'(bus.slv_dmi_valid_o), 128'(2'b00));
    step();
    bus.core_dmi_valid_i = 1'b0;
    bus.slv_dmi_valid_i  = 2'b10;
    #1;
    chk("post_tmo_ready", 128'(bus.slv_dmi_ready_o), 128'(2'b10));
    step();
    bus.slv_dmi_valid_i  = 2'b00;
    bus.core_dmi_valid_i = 1'b1;
    #1;
    chk("post_tmo_addr", 128'(bus.core_dmi_req_o.addr), 128'(7'h22));
    chk("post_tmo_valid", 128'(bus.slv_dmi_valid_o), 128'(2'b10));
    chk("post_tmo_data", 128'(bus.slv_dmi_resp_o[1].data),
        128'(32'hDEADBEEF));
    step();
    bus.core_dmi_valid_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
